// File: rtl/uart_word_tx_fifo_if.sv
`timescale 1ns/1ps
// uart_word_tx_fifo_if: producer-side bus of the buffered word UART transmitter.
//   master : drives data/send_en/Baud_Set/parity_odd and observes line and status.
//   slave  : the transmitter. It accepts words and reports line, Tx_Done, busy and FIFO status.
//   data[DATA_WIDTH]   word to enqueue
//   send_en            enqueue strobe
//   Baud_Set[3]        baud select 0..7
//   parity_odd         parity sense
//   uart_tx            serial line, idle high
//   Tx_Done            one-cycle pulse per completed word
//   uart_state         word being serialised
//   fifo_full          FIFO holds FIFO_DEPTH words
//   fifo_count[CNT_W]  words queued, excluding the word in the shifter
//   overflow           one-cycle pulse per dropped send_en
interface uart_word_tx_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] data;
    logic                  send_en;
    logic [2:0]            Baud_Set;
    logic                  parity_odd;
    logic                  uart_tx;
    logic                  Tx_Done;
    logic                  uart_state;
    logic                  fifo_full;
    logic [CNT_W-1:0]      fifo_count;
    logic                  overflow;

    modport master (
        output data, send_en, Baud_Set, parity_odd,
        input  uart_tx, Tx_Done, uart_state, fifo_full, fifo_count, overflow
    );

    modport slave (
        input  data, send_en, Baud_Set, parity_odd,
        output uart_tx, Tx_Done, uart_state, fifo_full, fifo_count, overflow
    );
endinterface

// File: rtl/uart_word_tx_fifo.sv
`timescale 1ns/1ps
// uart_word_tx_fifo: multi-byte UART transmitter fed by a word FIFO.
// Each DATA_WIDTH-bit word leaves the FIFO and goes out as DATA_WIDTH/8 back-to-back
// 8N1/8N2 frames, in the byte order set by MSB_FIRST. Bits within a byte go LSB first.
// Optional feature macro: UART_WTX_PARITY_EN. It adds a parity bit to each frame:
// even parity, or odd parity when parity_odd is high.
// Ports:
//   Clk  system clock, rising edge
//   Rst  asynchronous active-high reset
//   bus  uart_word_tx_fifo_if.slave. It carries data/send_en/Baud_Set/parity_odd in, and
//        uart_tx/Tx_Done/uart_state/fifo_full/fifo_count/overflow out.
module uart_word_tx_fifo #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MSB_FIRST   = 0,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic               Clk,
    input  logic               Rst,
    uart_word_tx_fifo_if.slave bus
);
    // Baud divisor. It is clamped to 1 so that a slow clock cannot stall the bit counter.
    function automatic int unsigned f_div(input int unsigned baud);
        return (CLK_FREQ_HZ / baud == 0) ? 1 : CLK_FREQ_HZ / baud;
    endfunction

    localparam int unsigned N_BYTES = DATA_WIDTH / 8;
    localparam int unsigned BYTE_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned DIV0 = f_div(9600);
    localparam int unsigned DIV1 = f_div(19200);
    localparam int unsigned DIV2 = f_div(38400);
    localparam int unsigned DIV3 = f_div(57600);
    localparam int unsigned DIV4 = f_div(115200);
    localparam int unsigned DIV5 = f_div(230400);
    localparam int unsigned DIV6 = f_div(460800);
    localparam int unsigned DIV7 = f_div(921600);
    localparam int unsigned DIV_W = $clog2(DIV0 + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_WTX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    function automatic logic [DIV_W-1:0] f_sel_div(input logic [2:0] sel);
        case (sel)
            3'd0:    return DIV_W'(DIV0);
            3'd1:    return DIV_W'(DIV1);
            3'd2:    return DIV_W'(DIV2);
            3'd3:    return DIV_W'(DIV3);
            3'd4:    return DIV_W'(DIV4);
            3'd5:    return DIV_W'(DIV5);
            3'd6:    return DIV_W'(DIV6);
            default: return DIV_W'(DIV7);
        endcase
    endfunction

    // FIFO storage and status
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_full;
    logic                  r_overflow;

    // Serialiser state
    logic [2:0]            r_state;
    logic [DIV_W-1:0]      r_baud_cnt;
    logic [DIV_W-1:0]      r_div;
    logic [2:0]            r_bit_idx;
    logic [BYTE_W-1:0]     r_byte_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_tx;
    logic                  r_done;
    logic                  r_busy;

    logic [2:0]            w_state_nxt;
    logic [DIV_W-1:0]      w_baud_cnt_nxt;
    logic [DIV_W-1:0]      w_div_nxt;
    logic [2:0]            w_bit_idx_nxt;
    logic [BYTE_W-1:0]     w_byte_idx_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  w_tx_nxt;
    logic                  w_done_nxt;
    logic                  w_busy_nxt;
    logic                  w_pop;
    logic                  w_push;
    logic [CNT_W-1:0]      w_count_nxt;
    logic                  w_bit_end;
    logic [7:0]            w_byte;

    // The byte on the wire is always at the outgoing end of the shifter.
    assign w_byte    = (MSB_FIRST != 0) ? r_shift[DATA_WIDTH-1 -: 8] : r_shift[7:0];
    assign w_bit_end = (r_baud_cnt == r_div - DIV_W'(1));
    // Full is sampled before the edge, so a pop on the same edge cannot rescue the write.
    assign w_push    = bus.send_en && !r_full;

`ifdef UART_WTX_PARITY_EN
    logic w_parity;
    assign w_parity = (^w_byte) ^ bus.parity_odd;
`else
    logic w_unused_parity;
    assign w_unused_parity = bus.parity_odd;
`endif

    // FIFO occupancy next value
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + CNT_W'(1);
        else if (w_pop && !w_push)
            w_count_nxt = r_count - CNT_W'(1);
    end

    // FIFO storage; no reset needed on the data array
    always_ff @(posedge Clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= bus.data;
    end

    // FIFO pointers, count, full and overflow
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
            r_overflow <= bus.send_en && r_full;
        end
    end

    // Serialiser next-state and datapath
    always_comb begin
        w_state_nxt    = r_state;
        w_baud_cnt_nxt = r_baud_cnt + DIV_W'(1);
        w_div_nxt      = r_div;
        w_bit_idx_nxt  = r_bit_idx;
        w_byte_idx_nxt = r_byte_idx;
        w_shift_nxt    = r_shift;
        w_tx_nxt       = r_tx;
        w_done_nxt     = 1'b0;
        w_busy_nxt     = r_busy;
        w_pop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt       = 1'b1;
                w_baud_cnt_nxt = '0;
                if (r_count != '0) begin
                    w_pop          = 1'b1;
                    w_shift_nxt    = r_mem[r_rd_ptr];
                    w_div_nxt      = f_sel_div(bus.Baud_Set);
                    w_byte_idx_nxt = '0;
                    w_tx_nxt       = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = '0;
                    w_bit_idx_nxt  = '0;
                    w_tx_nxt       = w_byte[0];
                    w_state_nxt    = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_nxt = '0;
`ifdef UART_WTX_PARITY_EN
                        w_tx_nxt      = w_parity;
                        w_state_nxt   = S_PARITY;
`else
                        w_tx_nxt      = 1'b1;
                        w_state_nxt   = S_STOP;
`endif
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt      = w_byte[r_bit_idx + 3'd1];
                    end
                end
            end
`ifdef UART_WTX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = '0;
                    w_tx_nxt       = 1'b1;
                    w_state_nxt    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = '0;
                    if (r_bit_idx != 3'(STOP_BITS - 1)) begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end else if (r_byte_idx == BYTE_W'(N_BYTES - 1)) begin
                        w_tx_nxt    = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        // Next byte starts immediately, without an idle gap
                        w_bit_idx_nxt  = '0;
                        w_byte_idx_nxt = r_byte_idx + BYTE_W'(1);
                        w_shift_nxt    = (MSB_FIRST != 0) ? (r_shift << 8) : (r_shift >> 8);
                        w_tx_nxt       = 1'b0;
                        w_state_nxt    = S_START;
                    end
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Serialiser state register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_div      <= DIV_W'(1);
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_div      <= w_div_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign bus.uart_tx    = r_tx;
    assign bus.Tx_Done    = r_done;
    assign bus.uart_state = r_busy;
    assign bus.fifo_full  = r_full;
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_overflow;
endmodule

// File: doc/uart_word_tx_fifo.md
# uart_word_tx_fifo

Parametrised multi-byte UART transmitter with an input word FIFO. It queues DATA_WIDTH-bit words and serialises each as DATA_WIDTH/8 back-to-back 8N1/8N2 frames (8E1/8O1 with the parity option) in a selectable byte order. It sits between the register/PLC data path and the UART pin and supersedes the single-word, unbuffered word transmitter. Producers can post bursts without waiting for each Tx_Done.

## Interface
- DATA_WIDTH, 32, word width; multiple of 8, range 8..64
- MSB_FIRST, 0, 1 = most significant byte sent first; 0 = least significant byte first (bits within a byte always LSB first)
- FIFO_DEPTH, 4, word entries; power of 2, ≥ 2
- CLK_FREQ_HZ, 50_000_000, Clk frequency used for baud divisors
- STOP_BITS, 1, 1 or 2

- Clk  in  1  system clock; all logic on rising edge
- Rst  in  1  asynchronous, active-high reset
- data  in  DATA_WIDTH  word to enqueue
- send_en  in  1  enqueue strobe, one word per cycle high
- Baud_Set  in  3  0..7 = 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600 baud
- parity_odd  in  1  parity sense (used only with UART_WTX_PARITY_EN)
- uart_tx  out  1  serial line, idle high
- Tx_Done  out  1  one-cycle pulse per completed word
- uart_state  out  1  high while a word is being serialised
- fifo_full  out  1  FIFO holds FIFO_DEPTH words
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words queued (excludes word in shifter)
- overflow  out  1  one-cycle pulse when a send_en is dropped

## Operation
- Reset values: uart_tx=1, Tx_Done=0, uart_state=0, fifo_full=0, fifo_count=0, overflow=0; FIFO emptied, FSM in IDLE. Reset mid-frame aborts immediately; no partial frame is completed.
- FIFO: send_en with fifo_full=0 writes data at the write pointer. send_en with fifo_full=1 drops the word and pulses overflow. Full is evaluated before the edge, so a simultaneous pop does not rescue the write. Pointers wrap modulo FIFO_DEPTH.
- Baud divisor DIV = CLK_FREQ_HZ / baud, integer-truncated; e.g. 434 cycles at 115200. Baud_Set is latched at word pop and held for the whole word.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when FIFO is non-empty, pop into the shift register, latch Baud_Set, clear byte index, go to START.
  - START: drive 0 for DIV cycles, then go to DATA.
  - DATA: drive 8 bits LSB first, DIV cycles each; then go to PARITY (option on) or STOP.
  - PARITY: drive the parity bit for DIV cycles, then go to STOP.
  - STOP: drive 1 for STOP_BITS*DIV cycles. If more bytes remain, advance the byte index and go to START with no gap. After the last byte, pulse Tx_Done and return to IDLE.
- Byte select: byte k of N=DATA_WIDTH/8 is data[8k+7:8k] when MSB_FIRST=0, and data[8(N-1-k)+7:8(N-1-k)] when MSB_FIRST=1.
- uart_state is high from the pop edge until the edge that pulses Tx_Done.
- Changes on data or Baud_Set after the pop edge have no effect on the word in flight.

## Timing
- send_en at edge E into an empty FIFO while IDLE: word is written at E and popped at E+1. uart_tx falls and uart_state rises after E+1. fifo_count reads 1 for exactly one cycle.
- Word duration from pop: N*(10+P+STOP_BITS-1)*DIV cycles, where P=1 with parity, else 0. Example: 32-bit, 115200, 1 stop, no parity = 4*10*434 = 17360 cycles.
- Tx_Done is registered and asserted in the cycle after the last stop period expires, coincident with entering IDLE.
- A queued word pops on the edge after Tx_Done. This gives exactly one idle-high cycle between words.
- Push and pop on the same edge with a non-full FIFO leave fifo_count unchanged.

## Configuration
- UART_WTX_PARITY_EN defined: PARITY state is compiled in. The parity bit is even parity (XOR of the 8 data bits) when parity_odd=0, inverted when parity_odd=1. Frames are 11 bits plus any extra stop bit.
- Not defined: PARITY state and logic are absent. parity_odd is ignored. Frames are 10 bits (1 stop) or 11 bits (2 stops).

## Test plan
- Reset: hold Rst high 10 cycles, including mid-frame. Expect uart_tx=1, uart_state=0, fifo_count=0, and no Tx_Done.
- Single word, LSB first, Baud_Set=4, 50 MHz: send 32'h01234567. Expect bytes 67, 45, 23, 01 on the line, 434-cycle bits, and a Tx_Done pulse 17360 cycles after the pop.
- MSB_FIRST=1, DATA_WIDTH=16: send 16'hA55A. Expect byte A5 then 5A.
- Burst: 5 consecutive send_en, DEPTH=4, idle FIFO. First word pops, four queue, no overflow. Expect 5 Tx_Done pulses, each followed by exactly one idle-high cycle.
- Overflow: fill FIFO to full during transmit, then send_en with 32'hDEADBEEF. Expect one overflow pulse, fifo_count stays 4, and DEADBEEF is never transmitted.
- With UART_WTX_PARITY_EN, parity_odd=0: send 8'h07. Expect parity bit 1 and an 11-bit frame. With parity_odd=1, expect parity bit 0.
